spi_config_loader: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 15 +
 rtl/cdc_sync.sv | 19 +
 rtl/spi_config_loader.sv | 107 ++++++++++
 tb/tb_spi_config_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and defaults for the SPI configuration loader.
// Frame width and settle delay track the ADC shift register.
package spi_cfg_pkg;

  localparam int CFG_WIDTH      = 180;
  localparam int SETTLE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    SETTLE,
    LOAD
  } state_t;

endpackage

// File: rtl/cdc_sync.sv
// Depth-N single-bit synchronizer for asynchronous SPI pins.
// No reset anywhere so the first stage stays a plain capture flop.
module cdc_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    sr <= {sr[N-2:0], d};
  end

  assign q = sr[N-1];

endmodule

// File: rtl/spi_config_loader.sv
// Counts SCLK edges per CS frame and applies well-formed frames
// to the shadow configuration register feeding the ADC core.
module spi_config_loader
  import spi_cfg_pkg::*;
#(
  parameter int WIDTH         = CFG_WIDTH,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs_b,
  input  logic             spi_sclk,
  input  logic [WIDTH-1:0] spi_bits,
  output logic [WIDTH-1:0] cfg_bits,
  output logic             cfg_update,
  output logic             frame_err,
  output logic [7:0]       load_count
);

  localparam int EW = $clog2(WIDTH + 2);

  logic          cs_s;
  logic          sclk_s;
  logic          sclk_q;
  logic          sclk_rise;
  logic [EW-1:0] edge_cnt;
  logic [3:0]    settle_cnt;
  state_t        state;

  cdc_sync #(.N(SYNC_STAGES)) u_cs_sync (
    .clk (clk),
    .d   (spi_cs_b),
    .q   (cs_s)
  );

  cdc_sync #(.N(SYNC_STAGES)) u_sclk_sync (
    .clk (clk),
    .d   (spi_sclk),
    .q   (sclk_s)
  );

  assign sclk_rise = sclk_s & ~sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      settle_cnt <= '0;
      sclk_q     <= 1'b0;
      cfg_bits   <= '0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      load_count <= '0;
    end else begin
      sclk_q     <= sclk_s;
      cfg_update <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!cs_s) begin
            edge_cnt <= '0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            if (edge_cnt == EW'(WIDTH)) begin
              settle_cnt <= 4'(SETTLE_CYCLES - 1);
              state      <= SETTLE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (sclk_rise &&
                       edge_cnt != EW'(WIDTH + 1)) begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        SETTLE: begin
          // CS re-asserted early: drop this frame quietly
          if (!cs_s) begin
            edge_cnt <= '0;
            state    <= ACTIVE;
          end else if (settle_cnt == '0) begin
            state <= LOAD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        LOAD: begin
          cfg_bits   <= spi_bits;
          cfg_update <= 1'b1;
          load_count <= load_count + 8'd1;
          frame_err  <= 1'b0;
          if (!cs_s) begin
            edge_cnt <= '0;
            state    <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_loader.sv
// Directed bench for spi_config_loader: full-width instance plus
// a narrow instance used to reach the load_count wrap quickly.
module tb_spi_config_loader;

  localparam int W  = 180;
  localparam int WS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_cs_b;
  logic          spi_sclk;
  logic [W-1:0]  spi_bits;
  logic [W-1:0]  cfg_bits;
  logic          cfg_update;
  logic          frame_err;
  logic [7:0]    load_count;
  logic [WS-1:0] cfg_bits_s;
  logic          cfg_update_s;
  logic          frame_err_s;
  logic [7:0]    load_count_s;

  int n_checks = 0;
  int n_pass   = 0;
  int upd      = 0;
  int upd_s    = 0;
  int dbl      = 0;
  logic upd_prev = 1'b0;

  always #5 clk = ~clk;

  spi_config_loader dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs_b   (spi_cs_b),
    .spi_sclk   (spi_sclk),
    .spi_bits   (spi_bits),
    .cfg_bits   (cfg_bits),
    .cfg_update (cfg_update),
    .frame_err  (frame_err),
    .load_count (load_count)
  );

  spi_config_loader #(.WIDTH(WS)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .spi_cs_b   (spi_cs_b),
    .spi_sclk   (spi_sclk),
    .spi_bits   (spi_bits[WS-1:0]),
    .cfg_bits   (cfg_bits_s),
    .cfg_update (cfg_update_s),
    .frame_err  (frame_err_s),
    .load_count (load_count_s)
  );

  always @(negedge clk) begin
    if (cfg_update) upd <= upd + 1;
    if (cfg_update && upd_prev) dbl <= dbl + 1;
    upd_prev <= cfg_update;
    if (cfg_update_s) upd_s <= upd_s + 1;
  end

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    spi_cs_b = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic edges(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic frame(input int n, input logic [W-1:0] pat);
    spi_cs_b = 1'b0;
    repeat (4) @(negedge clk);
    edges(n, 4);
    spi_bits = pat;
    repeat (2) @(negedge clk);
    spi_cs_b = 1'b1;
  endtask

  task automatic wait_upd(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (cfg_update) break;
    end
  endtask

  logic [W-1:0] pat_a;
  logic [W-1:0] pat_b;
  logic [W-1:0] pat_c;
  logic [WS-1:0] last_s;
  int lat;
  int u0;

  initial begin
    rst = 1'b1;
    spi_cs_b = 1'b1;
    spi_sclk = 1'b0;
    spi_bits = '0;
    pat_a = {45{4'hA}};
    pat_b = ~pat_a;
    pat_c = {45{4'h3}} ^ {20'hBEEF1, 160'd0};

    do_reset();
    check("rst_cfg_bits", cfg_bits, 0);
    check("rst_cfg_update", cfg_update, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_load_count", load_count, 0);

    // good frame
    u0 = upd;
    frame(180, pat_a);
    wait_upd(lat);
    check("good_latency", (lat >= 6 && lat <= 8), 1);
    check("good_cfg_bits", cfg_bits, pat_a);
    repeat (10) @(negedge clk);
    check("good_one_pulse", upd - u0, 1);
    check("good_load_count", load_count, 1);
    check("good_frame_err", frame_err, 0);

    // short frame then recovery
    do_reset();
    u0 = upd;
    frame(179, pat_b);
    repeat (14) @(negedge clk);
    check("short_cfg_bits", cfg_bits, 0);
    check("short_no_update", upd - u0, 0);
    check("short_frame_err", frame_err, 1);
    frame(180, pat_b);
    wait_upd(lat);
    check("recov_latency", (lat >= 6 && lat <= 8), 1);
    repeat (2) @(negedge clk);
    check("recov_frame_err", frame_err, 0);
    check("recov_load_count", load_count, 1);
    check("recov_cfg_bits", cfg_bits, pat_b);

    // long frame
    do_reset();
    u0 = upd;
    frame(181, pat_a);
    repeat (14) @(negedge clk);
    check("long_frame_err", frame_err, 1);
    check("long_load_count", load_count, 0);
    check("long_no_update", upd - u0, 0);

    // settle abort then normal frame
    do_reset();
    u0 = upd;
    frame(180, pat_a);
    repeat (2) @(negedge clk);
    spi_cs_b = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_update", upd - u0, 0);
    check("abort_frame_err", frame_err, 0);
    check("abort_load_count", load_count, 0);
    edges(180, 4);
    spi_bits = pat_c;
    repeat (2) @(negedge clk);
    spi_cs_b = 1'b1;
    wait_upd(lat);
    check("abort_next_latency", (lat >= 6 && lat <= 8), 1);
    check("abort_next_bits", cfg_bits, pat_c);
    repeat (2) @(negedge clk);
    check("abort_next_count", load_count, 1);
    check("abort_next_err", frame_err, 0);

    // reset mid-frame
    do_reset();
    frame(179, pat_b);
    repeat (14) @(negedge clk);
    frame(180, pat_a);
    wait_upd(lat);
    repeat (2) @(negedge clk);
    u0 = upd;
    spi_cs_b = 1'b0;
    repeat (4) @(negedge clk);
    edges(90, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cfg_bits", cfg_bits, 0);
    check("midrst_cfg_update", cfg_update, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_load_count", load_count, 0);
    edges(90, 4);
    repeat (2) @(negedge clk);
    spi_cs_b = 1'b1;
    repeat (14) @(negedge clk);
    check("midrst_frame_err_after", frame_err, 1);
    check("midrst_no_load", load_count, 0);
    check("midrst_no_update", upd - u0, 0);

    // wrap on narrow instance
    do_reset();
    u0 = upd_s;
    last_s = '0;
    for (int f = 0; f < 256; f++) begin
      spi_cs_b = 1'b0;
      repeat (3) @(negedge clk);
      edges(WS, 2);
      last_s = 8'($urandom_range(255));
      spi_bits[WS-1:0] = last_s;
      @(negedge clk);
      spi_cs_b = 1'b1;
      repeat (12) @(negedge clk);
      if (f == 0) check("wrap_first_bits", cfg_bits_s, last_s);
      if (f == 254) check("wrap_count_255", load_count_s, 255);
    end
    check("wrap_count_0", load_count_s, 0);
    check("wrap_pulses", upd_s - u0, 256);
    check("wrap_last_bits", cfg_bits_s, last_s);
    check("wrap_frame_err", frame_err_s, 0);
    check("pulse_never_merged", dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
